// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and stage-count helper for the chunked pipelined adder
package adder_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    function automatic int calc_nstg(input int width, input int chunk);
        return width / chunk;
    endfunction
endpackage

// File: rtl/adder_pipe_if.sv
// rtl/adder_pipe_if.sv - operand/result handshake bundle for adder_pipe
interface adder_pipe_if import adder_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) ();
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH:0]   o_sum;
    logic             o_ovf;

    modport slave (
        input  i_valid, i_a, i_b, i_sub, i_ready,
        output o_ready, o_valid, o_sum, o_ovf
    );

    modport master (
        output i_valid, i_a, i_b, i_sub, i_ready,
        input  o_ready, o_valid, o_sum, o_ovf
    );
endinterface

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - CHUNK-bit ripple adder slice with carry into its MSB exposed
module adder_chunk import adder_pkg::*; #(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cin_msb
);
    logic [CHUNK:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum  = full[CHUNK-1:0];
    assign cout = full[CHUNK];
    // sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out without a second adder
    assign cin_msb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
endmodule

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - valid/ready pipelined adder/subtractor, one CHUNK of carry chain per stage
module adder_pipe import adder_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    adder_pipe_if.slave bus
);
    localparam int NSTG = calc_nstg(WIDTH, CHUNK);

    logic [NSTG-1:0]            v;
    logic [NSTG-1:0]            adv;
    logic [NSTG-1:0]            en;
    logic [NSTG-1:0]            in_v;
    logic [NSTG-1:0][WIDTH-1:0] a_q, b_q, s_q;
    logic [NSTG-1:0]            c_q, sub_q;
    logic                       ovf_q;

    logic [NSTG-1:0][WIDTH-1:0] a_in, b_in, s_in, s_nx;
    logic [NSTG-1:0]            cin, sub_in;
    logic [NSTG-1:0][CHUNK-1:0] cs;
    logic [NSTG-1:0]            co, cm;

    // Walk back from the output: a stage moves when it is full and its successor has room.
    always_comb begin
        logic nxt_free;
        adv      = '0;
        nxt_free = bus.i_ready;
        for (int k = NSTG - 1; k >= 0; k--) begin
            adv[k]   = v[k] & nxt_free;
            nxt_free = ~v[k] | adv[k];
        end
    end

    assign en = ~v | adv;

    generate
        for (genvar k = 0; k < NSTG; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign in_v[k]   = bus.i_valid;
                assign a_in[k]   = bus.i_a;
                assign b_in[k]   = bus.i_sub ? ~bus.i_b : bus.i_b;
                assign s_in[k]   = '0;
                assign cin[k]    = bus.i_sub;
                assign sub_in[k] = bus.i_sub;
            end else begin : g_body
                assign in_v[k]   = v[k-1];
                assign a_in[k]   = a_q[k-1];
                assign b_in[k]   = b_q[k-1];
                assign s_in[k]   = s_q[k-1];
                assign cin[k]    = c_q[k-1];
                assign sub_in[k] = sub_q[k-1];
            end

            adder_chunk #(.CHUNK(CHUNK)) u_chunk (
                .a       (a_in[k][k*CHUNK +: CHUNK]),
                .b       (b_in[k][k*CHUNK +: CHUNK]),
                .cin     (cin[k]),
                .sum     (cs[k]),
                .cout    (co[k]),
                .cin_msb (cm[k])
            );

            assign s_nx[k] = s_in[k] | (WIDTH'(cs[k]) << (k * CHUNK));
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v     <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            sub_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (en[k]) begin
                    v[k] <= in_v[k];
                    if (in_v[k]) begin
                        a_q[k]   <= a_in[k];
                        b_q[k]   <= b_in[k];
                        s_q[k]   <= s_nx[k];
                        c_q[k]   <= co[k];
                        sub_q[k] <= sub_in[k];
                    end
                end
            end
            if (en[NSTG-1] && in_v[NSTG-1]) begin
                ovf_q <= co[NSTG-1] ^ cm[NSTG-1];
            end
        end
    end

    // Already-consumed operand chunks and inner MSB carries are deliberately left dangling.
    logic unused_ops;
    assign unused_ops = ^{a_q, b_q, cm};

    assign bus.o_ready = en[0];
    assign bus.o_valid = v[NSTG-1];
    assign bus.o_sum   = {c_q[NSTG-1] ^ sub_q[NSTG-1], s_q[NSTG-1]};
    assign bus.o_ovf   = ovf_q;
endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - directed and randomized self-checking bench for adder_pipe
module tb_adder_pipe;
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_pipe_if #(.WIDTH(16)) bus ();

    adder_pipe #(.WIDTH(16), .CHUNK(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    int          cyc      = 0;
    int          emit_cnt = 0;
    int          first_emit = 0;
    int          last_emit  = 0;
    bit          use_model = 1'b1;
    bit          hold_pend = 1'b0;
    logic [31:0] held;
    string       cur_tag = "init";
    op_t         op_q[$];
    logic [17:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [16:0] r;
        logic        o;
        if (s) begin
            r = {1'b0, a} - {1'b0, b};
            o = (a[15] != b[15]) && (r[15] != a[15]);
        end else begin
            r = {1'b0, a} + {1'b0, b};
            o = (a[15] == b[15]) && (r[15] != a[15]);
        end
        return {o, r};
    endfunction

    // Handshakes are judged at the falling edge; the transfer itself happens on the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend)
                check({cur_tag, "_hold"}, {13'b0, bus.o_valid, bus.o_ovf, bus.o_sum}, held);
            hold_pend = bus.o_valid && !bus.i_ready;
            held      = {13'b0, 1'b1, bus.o_ovf, bus.o_sum};
            if (bus.o_valid && bus.i_ready) begin
                if (exp_q.size() == 0) begin
                    check({cur_tag, "_spurious"}, 32'd1, 32'd0);
                end else begin
                    check(cur_tag, {14'b0, bus.o_ovf, bus.o_sum}, {14'b0, exp_q.pop_front()});
                end
                if (emit_cnt == 0) first_emit = cyc;
                last_emit = cyc;
                emit_cnt++;
            end
            if (bus.i_valid && bus.o_ready && use_model)
                exp_q.push_back(model(bus.i_a, bus.i_b, bus.i_sub));
        end
    end

    task automatic step(input bit want, input bit rdy, output bit ov);
        bus.i_valid = want && (op_q.size() > 0);
        if (op_q.size() > 0) begin
            bus.i_a   = op_q[0].a;
            bus.i_b   = op_q[0].b;
            bus.i_sub = op_q[0].s;
        end
        bus.i_ready = rdy;
        @(negedge clk);
        ov = bus.o_valid;
        if (bus.i_valid && bus.o_ready) begin
            void'(op_q.pop_front());
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [15:0] a, input logic [15:0] b, input logic s);
        op_t op;
        op.a = a;
        op.b = b;
        op.s = s;
        op_q.push_back(op);
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic s, input logic [17:0] exp);
        bit ov;
        int k;
        cur_tag   = tag;
        use_model = 1'b0;
        exp_q.push_back(exp);
        push_op(a, b, s);
        step(1'b1, 1'b1, ov);
        k = 0;
        step(1'b0, 1'b1, ov);
        while (!ov && k < 20) begin
            k++;
            step(1'b0, 1'b1, ov);
        end
        check({tag, "_lat"}, 32'(k), 32'd3);
        use_model = 1'b1;
    endtask

    task automatic drain(input string tag);
        bit ov;
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < 100) begin
            step(1'b0, 1'b1, ov);
            g++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [15:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        bit ov;
        bit any_v;
        int acc0;
        int guard;

        bus.i_valid = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_sub   = 1'b0;
        bus.i_ready = 1'b1;

        rst_n = 1'b0;
        step(1'b0, 1'b1, ov);
        step(1'b0, 1'b1, ov);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_sum",   32'(bus.o_sum),   32'd0);
        check("rst_ovf",   32'(bus.o_ovf),   32'd0);
        rst_n = 1'b1;
        step(1'b0, 1'b1, ov);
        check("rst_ready", 32'(bus.o_ready), 32'd1);

        directed("add_carry", 16'hFFFF, 16'h0001, 1'b0, {1'b0, 17'h10000});
        directed("add_ovf",   16'h7FFF, 16'h0001, 1'b0, {1'b1, 17'h08000});
        directed("sub_ovf",   16'h8000, 16'h0001, 1'b1, {1'b1, 17'h07FFF});
        directed("sub_borrow",16'h0000, 16'h0001, 1'b1, {1'b0, 17'h1FFFF});
        directed("sub_zero",  16'h0005, 16'h0005, 1'b1, {1'b0, 17'h00000});

        // Eight back-to-back operations must leave in eight consecutive cycles.
        cur_tag  = "stream";
        emit_cnt = 0;
        for (int i = 0; i < 8; i++) push_op(16'(16'h1111 * i), 16'(16'h0F0F + i), i[0]);
        guard = 0;
        while (op_q.size() > 0 && guard < 50) begin
            step(1'b1, 1'b1, ov);
            guard++;
        end
        check("stream_accept_cycles", 32'(guard), 32'd8);
        drain("stream");
        check("stream_emits", 32'(emit_cnt), 32'd8);
        check("stream_span",  32'(last_emit - first_emit), 32'd7);

        cur_tag = "stall";
        for (int i = 0; i < 8; i++) push_op(16'(16'h8421 + 16'h0313 * i), 16'(16'h7000 - i), ~i[0]);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, ov);
        check("stall_accepts", 32'(8 - op_q.size()), 32'd4);
        check("stall_ready",   32'(bus.o_ready), 32'd0);
        check("stall_valid",   32'(bus.o_valid), 32'd1);
        guard = 0;
        while (op_q.size() > 0 && guard < 50) begin
            step(1'b1, 1'b1, ov);
            guard++;
        end
        drain("stall");

        cur_tag = "flush";
        for (int i = 0; i < 3; i++) push_op(16'(16'h0100 * (i + 1)), 16'h0001, 1'b0);
        acc0 = n_acc;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, ov);
        check("flush_accepts", 32'(n_acc - acc0), 32'd3);
        rst_n = 1'b0;
        step(1'b0, 1'b1, ov);
        rst_n = 1'b1;
        exp_q.delete();
        check("flush_valid", 32'(bus.o_valid), 32'd0);
        check("flush_ready", 32'(bus.o_ready), 32'd1);
        any_v = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, ov);
            any_v |= ov;
        end
        check("flush_quiet", 32'(any_v), 32'd0);
        directed("post_rst", 16'h1234, 16'h1111, 1'b0, {1'b0, 17'h02345});

        cur_tag = "rand";
        acc0  = n_acc;
        guard = 0;
        while ((n_acc - acc0) < 10000 && guard < 60000) begin
            if (op_q.size() == 0) push_op(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, ov);
            guard++;
        end
        op_q.delete();
        check("rand_count", 32'(n_acc - acc0), 32'd10000);
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
